iob_2p_ram_fifo_ctrl: RTL and testbench



---
 rtl/iob_2p_ram_fifo_ctrl_pkg.sv | 16 +
 rtl/iob_2p_ram_fifo_ctrl_if.sv | 42 ++++
 rtl/iob_2p_ram_fifo_ctrl.sv | 89 ++++++++
 tb/tb_iob_2p_ram_fifo_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/iob_2p_ram_fifo_ctrl_pkg.sv
// Shared sizing helpers for the two-port-RAM FIFO controller.
package iob_2p_ram_fifo_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;

  function automatic int fifo_depth(input int addr_w);
    return 2 ** addr_w;
  endfunction

  // The level counter needs one extra bit so that a completely full FIFO is distinct from empty.
  function automatic int level_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/iob_2p_ram_fifo_ctrl_if.sv
// Push/pop user interface plus the RAM port signals the controller drives.
interface iob_2p_ram_fifo_ctrl_if
  import iob_2p_ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic                           clr;
  logic                           push;
  logic [DATA_W-1:0]              push_data;
  logic                           pop;
  logic [DATA_W-1:0]              pop_data;
  logic                           pop_valid;
  logic                           full;
  logic                           almost_full;
  logic                           empty;
  logic [level_width(ADDR_W)-1:0] level;
  logic                           overflow;
  logic                           underflow;

  logic                           mem_w_en;
  logic [ADDR_W-1:0]              mem_w_addr;
  logic [DATA_W-1:0]              mem_w_data;
  logic                           mem_r_en;
  logic [ADDR_W-1:0]              mem_r_addr;
  logic [DATA_W-1:0]              mem_r_data;

  // Master is the user plus the attached RAM; slave is the controller.
  modport master (
    output clr, push, push_data, pop, mem_r_data,
    input  pop_data, pop_valid, full, almost_full, empty, level, overflow, underflow,
    input  mem_w_en, mem_w_addr, mem_w_data, mem_r_en, mem_r_addr
  );

  modport slave (
    input  clr, push, push_data, pop, mem_r_data,
    output pop_data, pop_valid, full, almost_full, empty, level, overflow, underflow,
    output mem_w_en, mem_w_addr, mem_w_data, mem_r_en, mem_r_addr
  );

endinterface

// File: rtl/iob_2p_ram_fifo_ctrl.sv
// FIFO controller that writes and reads an external registered-output two-port RAM.
module iob_2p_ram_fifo_ctrl
  import iob_2p_ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int ALM_FULL_LVL = fifo_depth(ADDR_W) - 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  iob_2p_ram_fifo_ctrl_if.slave bus
);

  localparam int DEPTH = fifo_depth(ADDR_W);
  localparam int LVL_W = level_width(ADDR_W);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_d;
  logic              full_q;
  logic              empty_q;
  logic              almost_full_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              pop_valid_q;
  logic              push_ok;
  logic              pop_ok;

  // Acceptance looks only at registered status, so no combinational path from push to pop.
  assign push_ok = bus.push & ~full_q  & ~bus.clr;
  assign pop_ok  = bus.pop  & ~empty_q & ~bus.clr;

  always_comb begin
    level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    if (bus.clr) begin
      level_d = '0;
    end
  end

  assign bus.mem_w_en   = push_ok;
  assign bus.mem_w_addr = wr_ptr;
  assign bus.mem_w_data = bus.push_data;
  assign bus.mem_r_en   = pop_ok;
  assign bus.mem_r_addr = rd_ptr;

  // The RAM registers its read data, which lines up with the registered pop strobe.
  assign bus.pop_data    = bus.mem_r_data;
  assign bus.pop_valid   = pop_valid_q;
  assign bus.full        = full_q;
  assign bus.almost_full = almost_full_q;
  assign bus.empty       = empty_q;
  assign bus.level       = level_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      pop_valid_q   <= 1'b0;
    end else begin
      level_q       <= level_d;
      full_q        <= (level_d == LVL_W'(DEPTH));
      empty_q       <= (level_d == '0);
      almost_full_q <= (level_d >= LVL_W'(ALM_FULL_LVL));
      if (bus.clr) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
        pop_valid_q <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        if (bus.push && full_q) overflow_q  <= 1'b1;
        if (bus.pop && empty_q) underflow_q <= 1'b1;
        pop_valid_q <= pop_ok;
      end
    end
  end

endmodule

// File: tb/tb_iob_2p_ram_fifo_ctrl.sv
// Directed bench for the FIFO controller with a behavioural registered-read RAM alongside.
module tb_iob_2p_ram_fifo_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  iob_2p_ram_fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  iob_2p_ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Stand-in for iob_2p_ram: synchronous write, one-cycle registered read.
  logic [DATA_W-1:0] ram [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (bus.mem_w_en) ram[bus.mem_w_addr] <= bus.mem_w_data;
    if (bus.mem_r_en) bus.mem_r_data <= ram[bus.mem_r_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.clr = 1'b0;
    bus.push = 1'b0;
    bus.push_data = '0;
    bus.pop = 1'b0;

    // Reset state
    #12;
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_unf", 32'(bus.underflow), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_w_en", 32'(bus.mem_w_en), 32'd0);
    check("idle_r_en", 32'(bus.mem_r_en), 32'd0);

    // Three pushes then three back-to-back pops
    bus.push = 1'b1;
    bus.push_data = 8'h11; #1;
    check("p1_w_en", 32'(bus.mem_w_en), 32'd1);
    check("p1_w_addr", 32'(bus.mem_w_addr), 32'd0);
    tick();
    bus.push_data = 8'h22; tick();
    bus.push_data = 8'h33; #1;
    check("p3_w_addr", 32'(bus.mem_w_addr), 32'd2);
    tick();
    bus.push = 1'b0;
    check("lvl3", 32'(bus.level), 32'd3);
    bus.pop = 1'b1; #1;
    check("pop1_r_en", 32'(bus.mem_r_en), 32'd1);
    check("pop1_r_addr", 32'(bus.mem_r_addr), 32'd0);
    tick();
    check("pv1", 32'(bus.pop_valid), 32'd1);
    check("pd1", 32'(bus.pop_data), 32'h11);
    tick();
    check("pv2", 32'(bus.pop_valid), 32'd1);
    check("pd2", 32'(bus.pop_data), 32'h22);
    tick();
    bus.pop = 1'b0;
    check("pv3", 32'(bus.pop_valid), 32'd1);
    check("pd3", 32'(bus.pop_data), 32'h33);
    check("lvl0", 32'(bus.level), 32'd0);
    check("empty_after", 32'(bus.empty), 32'd1);
    tick();
    check("pv_end", 32'(bus.pop_valid), 32'd0);

    // Clear so the fill starts at address 0
    bus.clr = 1'b1; tick();
    bus.clr = 1'b0;
    check("clr_r_addr", 32'(bus.mem_r_addr), 32'd0);

    // Fill 32 words, watching almost_full and full
    bus.push = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.push_data = 8'(i);
      tick();
      if (i == 28) check("afull_lvl29", 32'(bus.almost_full), 32'd0);
      if (i == 29) check("afull_lvl30", 32'(bus.almost_full), 32'd1);
      if (i == 30) check("full_lvl31", 32'(bus.full), 32'd0);
    end
    check("full", 32'(bus.full), 32'd1);
    check("lvl32", 32'(bus.level), 32'd32);
    bus.push_data = 8'h55; #1;
    check("ovf_w_en", 32'(bus.mem_w_en), 32'd0);
    tick();
    check("ovf_lvl", 32'(bus.level), 32'd32);
    check("ovf_flag", 32'(bus.overflow), 32'd1);

    // Push and pop together while full
    bus.push_data = 8'hAA;
    bus.pop = 1'b1; #1;
    check("fp_w_en", 32'(bus.mem_w_en), 32'd0);
    check("fp_r_en", 32'(bus.mem_r_en), 32'd1);
    tick();
    bus.pop = 1'b0;
    check("fp_lvl", 32'(bus.level), 32'd31);
    check("fp_full", 32'(bus.full), 32'd0);
    check("fp_ovf", 32'(bus.overflow), 32'd1);
    check("fp_pd", 32'(bus.pop_data), 32'h00);
    #1;
    check("wrap_w_en", 32'(bus.mem_w_en), 32'd1);
    check("wrap_w_addr", 32'(bus.mem_w_addr), 32'd0);
    tick();
    bus.push = 1'b0;
    check("wrap_full", 32'(bus.full), 32'd1);
    bus.pop = 1'b1; tick();
    bus.pop = 1'b0;
    check("next_pd", 32'(bus.pop_data), 32'h01);

    // Underflow behaviour and clear
    bus.clr = 1'b1;
    bus.push = 1'b1; #1;
    check("clr_w_en", 32'(bus.mem_w_en), 32'd0);
    tick();
    bus.clr = 1'b0;
    bus.push = 1'b0;
    check("clr_ovf", 32'(bus.overflow), 32'd0);
    check("clr_empty", 32'(bus.empty), 32'd1);
    bus.pop = 1'b1; #1;
    check("unf_r_en", 32'(bus.mem_r_en), 32'd0);
    tick();
    check("unf_flag", 32'(bus.underflow), 32'd1);
    check("unf_pv", 32'(bus.pop_valid), 32'd0);
    bus.push = 1'b1;
    bus.push_data = 8'h77; #1;
    check("ep_w_en", 32'(bus.mem_w_en), 32'd1);
    check("ep_r_en", 32'(bus.mem_r_en), 32'd0);
    tick();
    bus.push = 1'b0;
    bus.pop = 1'b0;
    check("ep_lvl", 32'(bus.level), 32'd1);
    check("ep_unf", 32'(bus.underflow), 32'd1);
    bus.clr = 1'b1; tick();
    bus.clr = 1'b0;
    check("clr2_unf", 32'(bus.underflow), 32'd0);
    check("clr2_lvl", 32'(bus.level), 32'd0);

    // Asynchronous reset with pops in flight
    bus.push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.push_data = 8'(8'h40 + i);
      tick();
    end
    bus.push = 1'b0;
    check("ar_lvl5", 32'(bus.level), 32'd5);
    bus.pop = 1'b1; tick();
    check("ar_pv_before", 32'(bus.pop_valid), 32'd1);
    #2;
    rst_n = 1'b0; #1;
    check("ar_lvl", 32'(bus.level), 32'd0);
    check("ar_empty", 32'(bus.empty), 32'd1);
    check("ar_pv", 32'(bus.pop_valid), 32'd0);
    bus.pop = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_pv_after", 32'(bus.pop_valid), 32'd0);
    check("ar_lvl_after", 32'(bus.level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
